// File: rtl/id_decode_queue_if.sv
// id_decode_queue_if: fetch-side, dispatch-side and flush signals of the decode queue.
interface id_decode_queue_if #(
    parameter int FETCH_W  = 2,
    parameter int DECODE_W = 2,
    parameter int DEPTH    = 8,
    parameter int XLEN     = 32,
    parameter int CTRL_W   = 9
);
    logic                          flush_i;
    logic [FETCH_W-1:0]            if_valid_i;
    logic [FETCH_W*32-1:0]         if_instr_i;
    logic [FETCH_W*XLEN-1:0]       if_pc_i;
    logic                          if_ready_o;
    logic [DECODE_W-1:0]           id_valid_o;
    logic [DECODE_W*32-1:0]        id_instr_o;
    logic [DECODE_W*XLEN-1:0]      id_pc_o;
    logic [DECODE_W*CTRL_W-1:0]    id_ctrl_o;
    logic [$clog2(DECODE_W+1)-1:0] ds_accept_i;
    logic [$clog2(DEPTH+1)-1:0]    occupancy_o;

    modport slave (
        input  flush_i, if_valid_i, if_instr_i, if_pc_i, ds_accept_i,
        output if_ready_o, id_valid_o, id_instr_o, id_pc_o, id_ctrl_o, occupancy_o
    );
    modport master (
        output flush_i, if_valid_i, if_instr_i, if_pc_i, ds_accept_i,
        input  if_ready_o, id_valid_o, id_instr_o, id_pc_o, id_ctrl_o, occupancy_o
    );
endinterface

// File: rtl/id_decode_queue.sv
// id_decode_queue: multi-way circular instruction queue between fetch and dispatch,
// decoding the oldest DECODE_W entries with one control_unit per output lane.
module control_unit (
    input  logic [31:0] instr_i,
    output logic [8:0]  ctrl_o
);
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [2:0] alu_op;
    } control_type;

    control_type c;

    always_comb begin
        c = '0;
        case (instr_i[6:0])
            7'b0110011: begin c.reg_write = 1'b1; c.alu_op = 3'd2; end
            7'b0010011: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'd3; end
            7'b0000011: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.mem_read = 1'b1; end
            7'b0100011: begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
            7'b1100011: begin c.branch = 1'b1; c.alu_op = 3'd1; end
            7'b1101111: begin c.reg_write = 1'b1; c.jump = 1'b1; end
            7'b1100111: begin c.reg_write = 1'b1; c.jump = 1'b1; c.alu_src = 1'b1; end
            7'b0110111: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'd4; end
            default: c = '0;
        endcase
    end

    assign ctrl_o = c;
endmodule

module id_decode_queue #(
    parameter int FETCH_W  = 2,
    parameter int DECODE_W = 2,
    parameter int DEPTH    = 8,
    parameter int XLEN     = 32
) (
    input logic            clk,
    input logic            reset_n,
    id_decode_queue_if.slave bus
);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH+1);
    localparam int CTRL_W = 9;

    logic [31:0]   instr_q [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_enq, n_avail, n_acc, n_deq;
    logic          if_ready, run;

    // readiness ignores any dequeue happening in the same cycle
    assign if_ready = (count_q <= CW'(DEPTH-FETCH_W)) && !bus.flush_i;

    always_comb begin
        n_enq = '0;
        run   = 1'b1;
        for (int k = 0; k < FETCH_W; k++) begin
            run   = run & bus.if_valid_i[k];
            n_enq = n_enq + (run ? CW'(1) : CW'(0));
        end
    end

    assign n_avail = (count_q < CW'(DECODE_W)) ? count_q : CW'(DECODE_W);
    assign n_acc   = CW'(bus.ds_accept_i);
    assign n_deq   = bus.flush_i ? '0 : ((n_acc < n_avail) ? n_acc : n_avail);
    assign head_d  = bus.flush_i ? '0 : head_q + PW'(n_deq);
    assign tail_d  = bus.flush_i ? '0 : tail_q + (if_ready ? PW'(n_enq) : '0);
    assign count_d = bus.flush_i ? '0 : count_q + (if_ready ? n_enq : '0) - n_deq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= 32'h0000_0013;
                pc_q[i]    <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int k = 0; k < FETCH_W; k++) begin
                if (if_ready && CW'(k) < n_enq) begin
                    instr_q[tail_q + PW'(k)] <= bus.if_instr_i[k*32 +: 32];
                    pc_q[tail_q + PW'(k)]    <= bus.if_pc_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    assign bus.if_ready_o  = if_ready;
    assign bus.occupancy_o = count_q;

    for (genvar k = 0; k < DECODE_W; k++) begin : g_lane
        logic [PW-1:0] idx;
        assign idx                         = head_q + PW'(k);
        assign bus.id_valid_o[k]           = (CW'(k) < count_q) && !bus.flush_i;
        assign bus.id_instr_o[k*32 +: 32]  = instr_q[idx];
        assign bus.id_pc_o[k*XLEN +: XLEN] = pc_q[idx];
        control_unit u_cu (
            .instr_i(instr_q[idx]),
            .ctrl_o (bus.id_ctrl_o[k*CTRL_W +: CTRL_W])
        );
    end
endmodule

// File: tb/tb_id_decode_queue.sv
// tb_id_decode_queue: directed vectors for the decode queue with hand-computed expectations.
module tb_id_decode_queue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] next_pc, exp_pc;
    logic [1:0]  v;

    always #5 clk = ~clk;

    id_decode_queue_if #(.FETCH_W(2), .DECODE_W(2), .DEPTH(8), .XLEN(32), .CTRL_W(9)) bus ();

    id_decode_queue #(.FETCH_W(2), .DECODE_W(2), .DEPTH(8), .XLEN(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vv, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [1:0] acc, input logic f);
        bus.if_valid_i  = vv;
        bus.if_pc_i     = {p1, p0};
        bus.if_instr_i  = {p1[11:0], 20'h00013, p0[11:0], 20'h00013};
        bus.ds_accept_i = acc;
        bus.flush_i     = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        check("rst_valid", bus.id_valid_o, 2'b00);
        check("rst_occ", bus.occupancy_o, 0);
        check("rst_ready", bus.if_ready_o, 1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("post_rst_valid", bus.id_valid_o, 2'b00);
        check("post_rst_occ", bus.occupancy_o, 0);
        check("post_rst_ready", bus.if_ready_o, 1);

        // basic flow: addi + sw, then both consumed
        drive(2'b11, 32'h100, 32'h104, 2'd2, 1'b0);
        bus.if_instr_i = {32'h0011_2023, 32'h00A0_0093};
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
        #1;
        check("basic_valid", bus.id_valid_o, 2'b11);
        check("basic_pc0", bus.id_pc_o[31:0], 32'h100);
        check("basic_pc1", bus.id_pc_o[63:32], 32'h104);
        check("basic_instr1", bus.id_instr_o[63:32], 32'h0011_2023);
        check("basic_ctrl0", bus.id_ctrl_o[8:0], 9'h183);
        check("basic_ctrl1", bus.id_ctrl_o[17:9], 9'h0A0);
        tick();
        check("basic_occ", bus.occupancy_o, 0);
        check("basic_drained", bus.id_valid_o, 2'b00);

        // partial accept then over-accept
        drive(2'b11, 32'h100, 32'h104, 2'd0, 1'b0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
        #1;
        check("part_occ2", bus.occupancy_o, 2);
        tick();
        check("part_pc0", bus.id_pc_o[31:0], 32'h104);
        check("part_valid", bus.id_valid_o, 2'b01);
        check("part_occ", bus.occupancy_o, 1);
        drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
        tick();
        check("overacc_occ", bus.occupancy_o, 0);

        // non-contiguous valid writes nothing
        drive(2'b10, 32'h500, 32'h504, 2'd0, 1'b0);
        tick();
        check("noncontig_occ", bus.occupancy_o, 0);
        check("noncontig_valid", bus.id_valid_o, 2'b00);

        // fill to full, then stream across the pointer wrap
        next_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, next_pc, next_pc + 32'h4, 2'd0, 1'b0);
            tick();
            next_pc = next_pc + 32'h8;
        end
        check("full_occ", bus.occupancy_o, 8);
        check("full_ready", bus.if_ready_o, 0);
        exp_pc = 32'h100;
        for (int c = 0; c < 40 && exp_pc < 32'h140; c++) begin
            v = (next_pc < 32'h140) ? 2'b11 : 2'b00;
            drive(v, next_pc, next_pc + 32'h4, 2'd2, 1'b0);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (bus.id_valid_o[k]) begin
                    check("wrap_pc", bus.id_pc_o[k*32 +: 32], exp_pc);
                    exp_pc = exp_pc + 32'h4;
                end
            end
            if (bus.if_ready_o && v == 2'b11) next_pc = next_pc + 32'h8;
            tick();
        end
        check("wrap_done", exp_pc, 32'h140);
        check("wrap_occ", bus.occupancy_o, 0);

        // flush with six entries queued
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 32'h180 + 32'(i*8), 32'h184 + 32'(i*8), 2'd0, 1'b0);
            tick();
        end
        check("pre_flush_occ", bus.occupancy_o, 6);
        drive(2'b11, 32'h200, 32'h204, 2'd2, 1'b1);
        #1;
        check("flush_valid", bus.id_valid_o, 2'b00);
        check("flush_ready", bus.if_ready_o, 0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #1;
        check("post_flush_occ", bus.occupancy_o, 0);
        check("post_flush_valid", bus.id_valid_o, 2'b00);
        drive(2'b11, 32'h300, 32'h304, 2'd0, 1'b0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
        #1;
        check("refill_valid", bus.id_valid_o, 2'b11);
        check("refill_pc0", bus.id_pc_o[31:0], 32'h300);

        // asynchronous reset mid-operation
        reset_n = 1'b0;
        #1;
        check("async_rst_occ", bus.occupancy_o, 0);
        check("async_rst_valid", bus.id_valid_o, 2'b00);
        check("async_rst_ready", bus.if_ready_o, 1);
        tick();
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
